// File: rtl/fpu_op_issue_pkg.sv
// Shared types and constants for the FPU request front end.
package fpu_pkg;

  typedef enum logic [7:0] {
    OP_ADD = 8'h80,
    OP_SUB = 8'h81,
    OP_MUL = 8'h82,
    OP_DIV = 8'h83
  } OP_T;

  typedef enum logic [1:0] {
    RM_NEAREST = 2'd0,
    RM_TO_ZERO = 2'd1,
    RM_TO_POS  = 2'd2,
    RM_TO_NEG  = 2'd3
  } RMODE_T;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_ILLEGAL = 2'd1,
    ERR_TIMEOUT = 2'd2
  } ERR_T;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } STATE_T;

  // One queued request; op is raw because illegal codes must survive the FIFO.
  typedef struct packed {
    logic [7:0]  op;
    logic [1:0]  rmode;
    logic [31:0] a;
    logic [31:0] b;
  } REQ_T;

  localparam int          REQ_W    = $bits(REQ_T);
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [4:0]  FLAG_INV = 5'b10000;

  function automatic logic op_legal(input logic [7:0] op);
    return op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV};
  endfunction

endpackage

// File: rtl/fpu_op_issue_if.sv
// Request / FPU / response bundle of the FPU issue front end.
interface fpu_op_issue_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [7:0]  req_op_i;
  logic [1:0]  req_rmode_i;
  logic [31:0] req_a_i;
  logic [31:0] req_b_i;
  logic        fpu_start_o;
  logic [7:0]  fpu_op_o;
  logic [1:0]  fpu_rmode_o;
  logic [31:0] fpu_a_o;
  logic [31:0] fpu_b_o;
  logic        fpu_done_i;
  logic [31:0] fpu_result_i;
  logic [4:0]  fpu_flags_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_result_o;
  logic [4:0]  rsp_flags_o;
  logic [1:0]  rsp_err_o;
  logic        busy_o;

  // Requester / FPU / response consumer side.
  modport master (
    output req_valid_i, req_op_i, req_rmode_i, req_a_i, req_b_i,
    output fpu_done_i, fpu_result_i, fpu_flags_i, rsp_ready_i,
    input  req_ready_o, fpu_start_o, fpu_op_o, fpu_rmode_o, fpu_a_o, fpu_b_o,
    input  rsp_valid_o, rsp_result_o, rsp_flags_o, rsp_err_o, busy_o
  );

  // Issue block side.
  modport slave (
    input  req_valid_i, req_op_i, req_rmode_i, req_a_i, req_b_i,
    input  fpu_done_i, fpu_result_i, fpu_flags_i, rsp_ready_i,
    output req_ready_o, fpu_start_o, fpu_op_o, fpu_rmode_o, fpu_a_o, fpu_b_o,
    output rsp_valid_o, rsp_result_o, rsp_flags_o, rsp_err_o, busy_o
  );
endinterface

// File: rtl/fpu_req_fifo.sv
// Generic synchronous FIFO; wrap-bit pointers distinguish full from empty.
module fpu_req_fifo #(
  parameter int WIDTH = 74,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    r_wptr, r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  // Pointer update; push and pop in one cycle are independent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push && !o_full)  r_wptr <= r_wptr + PW'(1);
      if (i_pop  && !o_empty) r_rptr <= r_rptr + PW'(1);
    end
  end

  // Storage write; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (i_push && !o_full) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr[AW-1:0]];
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
endmodule

// File: rtl/fpu_op_issue.sv
// FPU issue front end: request FIFO, one-at-a-time issue FSM with hang
// timeout, and an in-order held response register.
module fpu_op_issue
  import fpu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input logic           clk,
  input logic           rst_n,
  fpu_op_issue_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT);

  STATE_T          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_start;
  logic [7:0]      r_op;
  logic [1:0]      r_rmode;
  logic [31:0]     r_a, r_b;
  logic            r_rsp_valid;
  logic [31:0]     r_result;
  logic [4:0]      r_flags;
  ERR_T            r_err;

  REQ_T            w_req, w_head;
  logic [REQ_W-1:0] w_rdata;
  logic            w_full, w_empty, w_push, w_pop;

  assign w_req  = '{op: bus.req_op_i, rmode: bus.req_rmode_i, a: bus.req_a_i, b: bus.req_b_i};
  assign w_head = w_rdata;
  assign w_push = bus.req_valid_i && !w_full;
  assign w_pop  = (r_state == S_IDLE) && !w_empty;

  fpu_req_fifo #(.WIDTH(REQ_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (w_req),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Issue FSM; start is raised on the pop edge so it is high exactly in ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_start     <= 1'b0;
      r_op        <= '0;
      r_rmode     <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_rsp_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
      r_err       <= ERR_OK;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        S_IDLE: if (!w_empty) begin
          r_op    <= w_head.op;
          r_rmode <= w_head.rmode;
          r_a     <= w_head.a;
          r_b     <= w_head.b;
          if (op_legal(w_head.op)) begin
            r_start <= 1'b1;
            r_state <= S_ISSUE;
          end else begin
            r_result    <= QNAN;
            r_flags     <= FLAG_INV;
            r_err       <= ERR_ILLEGAL;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // done beats a simultaneous timeout
          if (bus.fpu_done_i) begin
            r_result    <= bus.fpu_result_i;
            r_flags     <= bus.fpu_flags_i;
            r_err       <= ERR_OK;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_result    <= QNAN;
            r_flags     <= FLAG_INV;
            r_err       <= ERR_TIMEOUT;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RESP: if (bus.rsp_ready_i) begin
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready_o  = !w_full;
  assign bus.fpu_start_o  = r_start;
  assign bus.fpu_op_o     = r_op;
  assign bus.fpu_rmode_o  = r_rmode;
  assign bus.fpu_a_o      = r_a;
  assign bus.fpu_b_o      = r_b;
  assign bus.rsp_valid_o  = r_rsp_valid;
  assign bus.rsp_result_o = r_result;
  assign bus.rsp_flags_o  = r_flags;
  assign bus.rsp_err_o    = r_err;
  assign bus.busy_o       = !w_empty || (r_state != S_IDLE);
endmodule

// File: tb/tb_fpu_op_issue.sv
// Bench for fpu_op_issue: FPU stub, response scoreboard, scenario tasks.
module tb_fpu_op_issue;
  import fpu_pkg::*;

  localparam int          DEPTH   = 4;
  localparam int          TIMEOUT = 64;
  localparam int          FPU_LAT = 5;
  localparam logic [31:0] HANG_A  = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  flags;
    logic [1:0]  err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  fpu_op_issue_if bus();

  fpu_op_issue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // FPU stub: result after FPU_LAT cycles, never answers when A == HANG_A.
  logic        m_busy, m_hang, m_done, stray_done;
  int          m_cnt;
  logic [7:0]  m_op;
  logic [1:0]  m_rm;
  logic [31:0] m_a, m_b, m_res;
  logic [4:0]  m_flags;

  function automatic logic [31:0] fpu_res(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == OP_ADD && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return a ^ b ^ {24'h0, op};
  endfunction

  function automatic exp_t ok_exp(input logic [7:0] op, input logic [1:0] rm, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.res = fpu_res(op, a, b); e.flags = {3'b000, rm}; e.err = ERR_OK;
    return e;
  endfunction

  assign bus.fpu_done_i   = m_done | stray_done;
  assign bus.fpu_result_i = m_res;
  assign bus.fpu_flags_i  = m_flags;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_hang <= 0; m_done <= 0; m_cnt <= 0;
      m_op <= 0; m_rm <= 0; m_a <= 0; m_b <= 0; m_res <= 0; m_flags <= 0;
    end else begin
      m_done <= 1'b0;
      if (bus.fpu_start_o) begin
        m_busy <= 1'b1; m_cnt <= 1; m_hang <= (bus.fpu_a_o == HANG_A);
        m_op <= bus.fpu_op_o; m_rm <= bus.fpu_rmode_o; m_a <= bus.fpu_a_o; m_b <= bus.fpu_b_o;
      end else if (m_busy && !m_hang) begin
        if (m_cnt == FPU_LAT - 1) begin
          m_done <= 1'b1; m_busy <= 1'b0;
          m_res <= fpu_res(m_op, m_a, m_b); m_flags <= {3'b000, m_rm};
        end
        m_cnt <= m_cnt + 1;
      end
    end
  end

  // Response scoreboard and operand-hold check, sampled mid low phase.
  always @(negedge clk) begin
    #2;
    if (rst_n && m_done) begin
      checks++;
      if ({bus.fpu_op_o, bus.fpu_rmode_o, bus.fpu_a_o, bus.fpu_b_o} !== {m_op, m_rm, m_a, m_b}) begin
        errors++;
        $display("FAIL operand_hold: got %h/%h/%h/%h want %h/%h/%h/%h", bus.fpu_op_o, bus.fpu_rmode_o,
                 bus.fpu_a_o, bus.fpu_b_o, m_op, m_rm, m_a, m_b);
      end
    end
    if (rst_n && bus.rsp_valid_o && bus.rsp_ready_i) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: got result %h err %0d, want no response", bus.rsp_result_o, bus.rsp_err_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({bus.rsp_result_o, bus.rsp_flags_o, bus.rsp_err_o} !== {e.res, e.flags, e.err}) begin
          errors++;
          $display("FAIL rsp: got result %h flags %b err %0d, want result %h flags %b err %0d",
                   bus.rsp_result_o, bus.rsp_flags_o, bus.rsp_err_o, e.res, e.flags, e.err);
        end
      end
    end
  end

  // Drive one request (entered at a negedge), record its expected response.
  task automatic push(input logic [7:0] op, input logic [1:0] rm, input logic [31:0] a,
                      input logic [31:0] b, input exp_t e);
    int n = 0;
    bus.req_valid_i = 1'b1; bus.req_op_i = op; bus.req_rmode_i = rm;
    bus.req_a_i = a; bus.req_b_i = b;
    while (!bus.req_ready_o && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL push_accept: req_ready_o stayed %b, want 1", bus.req_ready_o);
    end else sb.push_back(e);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin @(negedge clk); n++; end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, want 0", sb.size());
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    logic [116:0] got;
    got = {bus.req_ready_o, bus.fpu_start_o, bus.rsp_valid_o, bus.busy_o, bus.rsp_err_o,
           bus.rsp_flags_o, bus.rsp_result_o, bus.fpu_op_o, bus.fpu_rmode_o, bus.fpu_a_o, bus.fpu_b_o};
    checks++;
    if (got !== {1'b1, 116'd0}) begin
      errors++;
      $display("FAIL %s: outputs %h, want %h", tag, got, {1'b1, 116'd0});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_values");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_reset_idle");
  endtask

  task automatic test_add();
    exp_t e;
    e.res = 32'h4040_0000; e.flags = 5'b00000; e.err = ERR_OK;
    bus.rsp_ready_i = 1'b1;
    push(OP_ADD, 2'd0, 32'h3F80_0000, 32'h4000_0000, e);
    @(negedge clk);
    checks++;
    if (bus.fpu_start_o !== 1'b1) begin
      errors++; $display("FAIL add_start_latency: start %b, want 1", bus.fpu_start_o);
    end
    @(negedge clk);
    checks++;
    if (bus.fpu_start_o !== 1'b0) begin
      errors++; $display("FAIL add_start_width: start %b, want 0", bus.fpu_start_o);
    end
    drain(50);
    checks++;
    if (bus.busy_o !== 1'b0) begin
      errors++; $display("FAIL add_idle_busy: busy %b, want 0", bus.busy_o);
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    bit   seen = 0;
    int   n = 0;
    e.res = QNAN; e.flags = FLAG_INV; e.err = ERR_ILLEGAL;
    bus.rsp_ready_i = 1'b1;
    push(8'h84, 2'd1, 32'h1234_5678, 32'h9ABC_DEF0, e);
    while (sb.size() != 0 && n < 30) begin
      if (bus.fpu_start_o) seen = 1;
      @(negedge clk); n++;
    end
    checks++;
    if (seen || sb.size() != 0) begin
      errors++; $display("FAIL illegal_no_start: start seen %b pending %0d, want 0 and 0", seen, sb.size());
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    exp_t e;
    int   n = 0;
    e.res = QNAN; e.flags = FLAG_INV; e.err = ERR_TIMEOUT;
    bus.rsp_ready_i = 1'b1;
    push(OP_ADD, 2'd0, HANG_A, 32'h0000_0001, e);
    fork
      push(OP_MUL, 2'd1, 32'h40A0_0000, 32'h3F00_0000, ok_exp(OP_MUL, 2'd1, 32'h40A0_0000, 32'h3F00_0000));
      begin
        int w = 0;
        while (!bus.fpu_start_o && w < 10) begin @(negedge clk); w++; end
        while (!bus.rsp_valid_o && n < 200) begin @(negedge clk); n++; end
        // n counts from the cycle start is visible; the FPU samples it one edge later.
        checks++;
        if (n - 1 != TIMEOUT) begin
          errors++; $display("FAIL timeout_latency: %0d cycles, want %0d", n - 1, TIMEOUT);
        end
      end
    join
    drain(100);
  endtask

  task automatic test_backpressure();
    logic [38:0] held;
    int          n = 0;
    bus.rsp_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      logic [7:0]  op;
      logic [31:0] a, b;
      op = 8'h80 + 8'(i % 4); a = 32'h1000_0000 + 32'(i * 17); b = 32'h0F0F_0000 ^ 32'(i << 4);
      push(op, 2'(i), a, b, ok_exp(op, 2'(i), a, b));
    end
    checks++;
    if (bus.req_ready_o !== 1'b0) begin
      errors++; $display("FAIL full_ready: req_ready_o %b, want 0", bus.req_ready_o);
    end
    while (!bus.rsp_valid_o && n < 50) begin @(negedge clk); n++; end
    held = {bus.rsp_result_o, bus.rsp_flags_o, bus.rsp_err_o};
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.rsp_valid_o, bus.fpu_start_o, bus.req_ready_o, bus.rsp_result_o, bus.rsp_flags_o, bus.rsp_err_o}
          !== {3'b100, held}) begin
        errors++;
        $display("FAIL stall_stable: valid %b start %b ready %b rsp %h, want 1 0 0 %h", bus.rsp_valid_o,
                 bus.fpu_start_o, bus.req_ready_o, {bus.rsp_result_o, bus.rsp_flags_o, bus.rsp_err_o}, held);
      end
    end
    bus.rsp_ready_i = 1'b1;
    drain(300);
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    bus.rsp_ready_i = 1'b1;
    push(OP_ADD, 2'd0, HANG_A, 32'h0, ok_exp(OP_ADD, 2'd0, HANG_A, 32'h0));
    for (int i = 0; i < 3; i++)
      push(OP_SUB, 2'd2, 32'h4000_0000 + 32'(i), 32'h1, ok_exp(OP_SUB, 2'd2, 32'h4000_0000 + 32'(i), 32'h1));
    repeat (5) @(negedge clk);
    checks++;
    if (bus.busy_o !== 1'b1 || bus.rsp_valid_o !== 1'b0) begin
      errors++; $display("FAIL mid_wait: busy %b valid %b, want 1 0", bus.busy_o, bus.rsp_valid_o);
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset_values");
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus.rsp_valid_o || bus.fpu_start_o) seen = 1;
      @(negedge clk);
    end
    checks++;
    if (seen || bus.busy_o !== 1'b0) begin
      errors++; $display("FAIL stray_done: activity %b busy %b, want 0 0", seen, bus.busy_o);
    end
  endtask

  initial begin
    bus.req_valid_i = 1'b0; bus.req_op_i = '0; bus.req_rmode_i = '0;
    bus.req_a_i = '0; bus.req_b_i = '0; bus.rsp_ready_i = 1'b0; stray_done = 1'b0;
    @(negedge clk);
    test_reset();
    test_add();
    test_illegal();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
